// File: rtl/spi_regbank_pkg.sv
// Shared definitions for the SPI register-bank slave: header layout, FSM state
// and the packed FSM register that doubles as the observable debug state.
package spi_regbank_pkg;

    localparam int HDR_BITS     = 8;
    localparam int HDR_RW       = 7;
    localparam int HDR_AI       = 6;
    localparam int HDR_ADDR_MSB = 5;
    localparam int HDR_ADDR_LSB = 0;
    localparam int ADDR_W       = 6;
    localparam int CNT_W        = 5;

    typedef enum logic {
        HDR  = 1'b0,
        DATA = 1'b1
    } state_e;

    typedef struct packed {
        state_e             state;
        logic [CNT_W-1:0]   bit_cnt;
        logic               rw;
        logic               ai;
        logic               addr_ok;
        logic [ADDR_W-1:0]  addr;
    } fsm_t;

    function automatic logic addr_in_range(input logic [ADDR_W-1:0] a, input int num_regs);
        return (int'(a) < num_regs);
    endfunction

endpackage

// File: rtl/spi_regbank_slave_if.sv
// SPI pad-side bus of the register-bank slave; the clock stays a plain port.
// Handshake: a frame is the span with spi_cs_n low; mosi is sampled on rising
// sclk, miso changes on falling sclk, and spi_cs_n high aborts the frame at once.
interface spi_regbank_slave_if;
    logic spi_cs_n;
    logic spi_mosi;
    logic spi_miso;
    logic spi_miso_oe;

    modport master (output spi_cs_n, output spi_mosi, input spi_miso, input spi_miso_oe);
    modport slave  (input spi_cs_n, input spi_mosi, output spi_miso, output spi_miso_oe);
endinterface

// File: rtl/spi_tx_shifter.sv
// Falling-edge MISO shifter. A rising-edge load request is captured into a
// buffer and consumed by the very next falling edge, keeping dual-edge logic here.
module spi_tx_shifter #(
    parameter int DATA_W    = 16,
    parameter int MSB_FIRST = 1
) (
    input  logic              spi_sclk,
    input  logic              rst_n,
    input  logic              cs_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    output logic              miso
);

    logic              ld_q;
    logic [DATA_W-1:0] buf_q;
    logic [DATA_W-1:0] tx_q;
    logic [DATA_W-1:0] src;

    always_ff @(posedge spi_sclk or negedge rst_n or posedge cs_n) begin
        if (!rst_n) begin
            ld_q  <= 1'b0;
            buf_q <= '0;
        end else if (cs_n) begin
            ld_q  <= 1'b0;
            buf_q <= '0;
        end else begin
            ld_q <= load;
            if (load) begin
                buf_q <= load_data;
            end
        end
    end

    // ld_q stays high for exactly one falling edge per load
    assign src = ld_q ? buf_q : tx_q;

    always_ff @(negedge spi_sclk or negedge rst_n or posedge cs_n) begin
        if (!rst_n) begin
            miso <= 1'b0;
            tx_q <= '0;
        end else if (cs_n) begin
            miso <= 1'b0;
            tx_q <= '0;
        end else if (MSB_FIRST != 0) begin
            miso <= src[DATA_W-1];
            tx_q <= {src[DATA_W-2:0], 1'b0};
        end else begin
            miso <= src[0];
            tx_q <= {1'b0, src[DATA_W-1:1]};
        end
    end

endmodule

// File: rtl/spi_regbank_slave.sv
// SPI mode-0 slave: 8-bit header then DATA_W-bit words that write or read a
// register bank. Everything runs on spi_sclk; spi_cs_n high aborts the frame.
module spi_regbank_slave
    import spi_regbank_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int NUM_REGS  = 16,
    parameter int MSB_FIRST = 1
) (
    input  logic                       spi_sclk,
    input  logic                       rst_n,
    spi_regbank_slave_if.slave         spi,
    output logic [NUM_REGS*DATA_W-1:0] regs_flat,
    output logic                       wr_toggle,
    output logic [5:0]                 last_wr_addr,
    output logic [7:0]                 frame_count,
    output logic                       err_addr
);

    localparam logic [CNT_W-1:0]  HDR_LAST  = CNT_W'(HDR_BITS - 1);
    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DATA_W - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

    logic                cs_n;
    logic                mosi;
    fsm_t                fsm_q;
    logic [DATA_W-1:0]   shift_q;
    logic [DATA_W-1:0]   shift_nxt;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [HDR_BITS-1:0] hdr_word;
    logic [ADDR_W-1:0]   hdr_addr;
    logic [ADDR_W-1:0]   addr_nxt;
    logic                hdr_ok;
    logic                hdr_done;
    logic                word_done;
    logic                commit;
    logic                tx_load;
    logic [DATA_W-1:0]   tx_data;
    logic [DATA_W-1:0]   rd_hdr;
    logic [DATA_W-1:0]   rd_nxt;
    logic                miso_w;

    assign cs_n = spi.spi_cs_n;
    assign mosi = spi.spi_mosi;

    always_comb begin
        hdr_word  = {shift_q[HDR_BITS-2:0], mosi};
        hdr_addr  = hdr_word[HDR_ADDR_MSB:HDR_ADDR_LSB];
        hdr_ok    = addr_in_range(hdr_addr, NUM_REGS);
        hdr_done  = (fsm_q.state == HDR)  && (fsm_q.bit_cnt == HDR_LAST);
        word_done = (fsm_q.state == DATA) && (fsm_q.bit_cnt == LAST_BIT);
        commit    = word_done && fsm_q.rw && fsm_q.addr_ok;

        // Header always arrives MSB first; only data words honour MSB_FIRST
        if ((fsm_q.state == DATA) && (MSB_FIRST == 0)) begin
            shift_nxt = {mosi, shift_q[DATA_W-1:1]};
        end else begin
            shift_nxt = {shift_q[DATA_W-2:0], mosi};
        end

        // Out-of-range addresses never advance, so they stay out of range
        addr_nxt = fsm_q.addr;
        if (fsm_q.ai && fsm_q.addr_ok) begin
            addr_nxt = (fsm_q.addr == LAST_ADDR) ? '0 : fsm_q.addr + 1'b1;
        end

        rd_hdr = '0;
        rd_nxt = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (hdr_addr == ADDR_W'(i)) rd_hdr = regs_q[i];
            if (addr_nxt == ADDR_W'(i)) rd_nxt = regs_q[i];
        end

        tx_load = (hdr_done && !hdr_word[HDR_RW]) || (word_done && !fsm_q.rw);
        tx_data = hdr_done ? rd_hdr : rd_nxt;
    end

    always_ff @(posedge spi_sclk or negedge rst_n or posedge cs_n) begin
        if (!rst_n) begin
            fsm_q   <= '0;
            shift_q <= '0;
        end else if (cs_n) begin
            fsm_q   <= '0;
            shift_q <= '0;
        end else begin
            shift_q <= shift_nxt;
            case (fsm_q.state)
                HDR: begin
                    if (hdr_done) begin
                        fsm_q.state   <= DATA;
                        fsm_q.bit_cnt <= '0;
                        fsm_q.rw      <= hdr_word[HDR_RW];
                        fsm_q.ai      <= hdr_word[HDR_AI];
                        fsm_q.addr_ok <= hdr_ok;
                        fsm_q.addr    <= hdr_addr;
                    end else begin
                        fsm_q.bit_cnt <= fsm_q.bit_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (word_done) begin
                        fsm_q.bit_cnt <= '0;
                        fsm_q.addr    <= addr_nxt;
                    end else begin
                        fsm_q.bit_cnt <= fsm_q.bit_cnt + 1'b1;
                    end
                end
                default: fsm_q <= '0;
            endcase
        end
    end

    // Bank and status survive frame aborts; only rst_n clears them
    always_ff @(posedge spi_sclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            wr_toggle    <= 1'b0;
            last_wr_addr <= '0;
            frame_count  <= '0;
            err_addr     <= 1'b0;
        end else begin
            if (hdr_done) begin
                frame_count <= frame_count + 8'd1;
                if (!hdr_ok) begin
                    err_addr <= 1'b1;
                end
            end
            if (commit) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (fsm_q.addr == ADDR_W'(i)) regs_q[i] <= shift_nxt;
                end
                wr_toggle    <= ~wr_toggle;
                last_wr_addr <= fsm_q.addr;
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[g*DATA_W +: DATA_W] = regs_q[g];
    end

    spi_tx_shifter #(
        .DATA_W    (DATA_W),
        .MSB_FIRST (MSB_FIRST)
    ) u_tx (
        .spi_sclk  (spi_sclk),
        .rst_n     (rst_n),
        .cs_n      (cs_n),
        .load      (tx_load),
        .load_data (tx_data),
        .miso      (miso_w)
    );

    assign spi.spi_miso    = miso_w;
    assign spi.spi_miso_oe = ~cs_n;

endmodule

// File: tb/tb_spi_regbank_slave.sv
// Self-checking bench: directed scenarios plus random frames against a
// frame-level model of the bank (array + modulo address arithmetic).
module tb_spi_regbank_slave;

    logic sclk  = 1'b0;
    logic rst_n = 1'b0;

    spi_regbank_slave_if spi ();
    spi_regbank_slave_if spi8 ();

    logic [255:0] regs_flat;
    logic         wr_toggle;
    logic [5:0]   last_wr_addr;
    logic [7:0]   frame_count;
    logic         err_addr;

    logic [31:0]  regs_flat8;
    logic         wr_toggle8;
    logic [5:0]   last_wr_addr8;
    logic [7:0]   frame_count8;
    logic         err_addr8;

    spi_regbank_slave #(.DATA_W(16), .NUM_REGS(16), .MSB_FIRST(1)) dut (
        .spi_sclk(sclk), .rst_n(rst_n), .spi(spi.slave),
        .regs_flat(regs_flat), .wr_toggle(wr_toggle), .last_wr_addr(last_wr_addr),
        .frame_count(frame_count), .err_addr(err_addr)
    );

    spi_regbank_slave #(.DATA_W(8), .NUM_REGS(4), .MSB_FIRST(0)) dut8 (
        .spi_sclk(sclk), .rst_n(rst_n), .spi(spi8.slave),
        .regs_flat(regs_flat8), .wr_toggle(wr_toggle8), .last_wr_addr(last_wr_addr8),
        .frame_count(frame_count8), .err_addr(err_addr8)
    );

    always #5 sclk = ~sclk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, got running sim, required finish");
        $fatal(1);
    end

    int errors = 0;
    int checks = 0;

    logic [15:0] m_regs [16];
    logic        m_tog;
    logic [5:0]  m_last;
    logic [7:0]  m_fc;
    logic        m_err;
    logic [15:0] exp_q [$];
    logic [15:0] tx_words [$];
    logic [15:0] rx_words [$];
    int          hdr_miso_bad;
    int          oe_bad;

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = '0;
        m_tog = 1'b0; m_last = '0; m_fc = '0; m_err = 1'b0;
    endfunction

    // Frame-level model: header fields, then one bank access per full word
    function automatic void model_frame(input logic [7:0] hdr, input int nfull);
        int a;
        bit ok;
        a  = int'(hdr[5:0]);
        ok = (a < 16);
        m_fc = m_fc + 8'd1;
        if (!ok) m_err = 1'b1;
        exp_q = {};
        for (int k = 0; k < nfull; k++) begin
            if (hdr[7]) begin
                if (ok) begin
                    m_regs[a] = tx_words[k];
                    m_tog = ~m_tog;
                    m_last = 6'(a);
                end
            end else begin
                exp_q.push_back(ok ? m_regs[a] : 16'h0000);
            end
            if (hdr[6] && ok) a = (a + 1) % 16;
        end
    endfunction

    function automatic logic [255:0] model_flat();
        logic [255:0] f;
        for (int i = 0; i < 16; i++) f[i*16 +: 16] = m_regs[i];
        return f;
    endfunction

    function automatic logic [15:0] model_status();
        return {m_tog, m_last, m_fc, m_err};
    endfunction

    // Drives header + tx_words (+ partial random bits), then raises cs_n
    task automatic spi_frame(input logic [7:0] hdr, input int partial_bits);
        logic [15:0] w;
        logic [15:0] r;
        hdr_miso_bad = 0;
        oe_bad = 0;
        rx_words = {};
        for (int i = 7; i >= 0; i--) begin
            @(negedge sclk);
            spi.spi_cs_n = 1'b0;
            spi.spi_mosi = hdr[i];
            @(posedge sclk); #1;
            if (spi.spi_miso !== 1'b0) hdr_miso_bad++;
            if (spi.spi_miso_oe !== 1'b1) oe_bad++;
        end
        for (int k = 0; k < tx_words.size(); k++) begin
            w = tx_words[k];
            r = '0;
            for (int i = 15; i >= 0; i--) begin
                @(negedge sclk);
                spi.spi_mosi = w[i];
                @(posedge sclk); #1;
                r[i] = spi.spi_miso;
            end
            rx_words.push_back(r);
        end
        for (int i = 0; i < partial_bits; i++) begin
            @(negedge sclk);
            spi.spi_mosi = 1'($urandom_range(0, 1));
        end
        @(negedge sclk);
        spi.spi_cs_n = 1'b1;
        spi.spi_mosi = 1'b0;
        @(negedge sclk);
    endtask

    task automatic spi8_frame(input logic [7:0] hdr, input logic [7:0] w, output logic [7:0] r);
        r = '0;
        for (int i = 7; i >= 0; i--) begin
            @(negedge sclk);
            spi8.spi_cs_n = 1'b0;
            spi8.spi_mosi = hdr[i];
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge sclk);
            spi8.spi_mosi = w[i];
            @(posedge sclk); #1;
            r[i] = spi8.spi_miso;
        end
        @(negedge sclk);
        spi8.spi_cs_n = 1'b1;
        spi8.spi_mosi = 1'b0;
        @(negedge sclk);
    endtask

    task automatic test_reset();
        checks++;
        if (regs_flat !== 256'd0) begin
            errors++; $display("FAIL reset_bank: got %h required 0", regs_flat);
        end
        checks++;
        if ({wr_toggle, last_wr_addr, frame_count, err_addr} !== 16'h0000) begin
            errors++; $display("FAIL reset_status: got %h required 0000", {wr_toggle, last_wr_addr, frame_count, err_addr});
        end
        checks++;
        if ({spi.spi_miso, spi.spi_miso_oe, regs_flat8, frame_count8} !== 42'd0) begin
            errors++; $display("FAIL reset_pins: got miso=%b oe=%b flat8=%h fc8=%h required all 0",
                               spi.spi_miso, spi.spi_miso_oe, regs_flat8, frame_count8);
        end
    endtask

    task automatic test_basic_write();
        tx_words = {16'hBEEF, 16'h1234};
        model_frame(8'hC2, 2);
        spi_frame(8'hC2, 0);
        checks++;
        if (regs_flat[2*16 +: 16] !== 16'hBEEF || regs_flat[3*16 +: 16] !== 16'h1234) begin
            errors++; $display("FAIL basic_regs: got reg2=%h reg3=%h required BEEF 1234",
                               regs_flat[2*16 +: 16], regs_flat[3*16 +: 16]);
        end
        checks++;
        if ({wr_toggle, last_wr_addr, frame_count} !== {1'b0, 6'd3, 8'd1}) begin
            errors++; $display("FAIL basic_status: got tog=%b last=%0d fc=%0d required 0 3 1",
                               wr_toggle, last_wr_addr, frame_count);
        end
        checks++;
        if (oe_bad != 0) begin
            errors++; $display("FAIL basic_oe: got %0d low samples required 0", oe_bad);
        end
    endtask

    task automatic test_readback();
        int bad;
        tx_words = {16'($urandom), 16'($urandom)};
        model_frame(8'h42, 2);
        spi_frame(8'h42, 0);
        bad = 0;
        if (rx_words.size() != 2) bad++;
        else if (rx_words[0] !== 16'hBEEF || rx_words[1] !== 16'h1234) bad++;
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL readback_data: got %h %h required BEEF 1234", rx_words[0], rx_words[1]);
        end
        checks++;
        if (hdr_miso_bad != 0) begin
            errors++; $display("FAIL readback_hdr_miso: got %0d nonzero bits required 0", hdr_miso_bad);
        end
        checks++;
        if (regs_flat !== model_flat() || frame_count !== 8'd2) begin
            errors++; $display("FAIL readback_bank: got %h fc=%0d required %h fc=2", regs_flat, frame_count, model_flat());
        end
    endtask

    task automatic test_wrap_noai();
        tx_words = {16'h0A0A, 16'h0B0B, 16'h0C0C};
        model_frame(8'hCF, 3);
        spi_frame(8'hCF, 0);
        checks++;
        if ({regs_flat[15*16 +: 16], regs_flat[0 +: 16], regs_flat[16 +: 16]} !== 48'h0A0A_0B0B_0C0C) begin
            errors++; $display("FAIL wrap_regs: got %h %h %h required 0A0A 0B0B 0C0C",
                               regs_flat[15*16 +: 16], regs_flat[0 +: 16], regs_flat[16 +: 16]);
        end
        tx_words = {16'h1111, 16'h2222};
        model_frame(8'h85, 2);
        spi_frame(8'h85, 0);
        checks++;
        if (regs_flat[5*16 +: 16] !== 16'h2222 || regs_flat[6*16 +: 16] !== 16'h0000) begin
            errors++; $display("FAIL noai_reg5: got reg5=%h reg6=%h required 2222 0000",
                               regs_flat[5*16 +: 16], regs_flat[6*16 +: 16]);
        end
        checks++;
        if ({wr_toggle, last_wr_addr, frame_count, err_addr} !== model_status()) begin
            errors++; $display("FAIL noai_status: got %h required %h",
                               {wr_toggle, last_wr_addr, frame_count, err_addr}, model_status());
        end
    endtask

    task automatic test_out_of_range();
        logic tog_before;
        tog_before = wr_toggle;
        tx_words = {16'hFFFF};
        model_frame(8'h90, 1);
        spi_frame(8'h90, 0);
        checks++;
        if (regs_flat !== model_flat() || err_addr !== 1'b1 || wr_toggle !== tog_before) begin
            errors++; $display("FAIL oor_write: got err=%b tog=%b bank=%h required err=1 tog=%b bank=%h",
                               err_addr, wr_toggle, regs_flat, tog_before, model_flat());
        end
        tx_words = {16'($urandom)};
        model_frame(8'h10, 1);
        spi_frame(8'h10, 0);
        checks++;
        if (rx_words[0] !== 16'h0000 || err_addr !== 1'b1) begin
            errors++; $display("FAIL oor_read: got miso word=%h err=%b required 0000 1", rx_words[0], err_addr);
        end
    endtask

    task automatic test_abort();
        tx_words = {};
        model_frame(8'hC5, 0);
        spi_frame(8'hC5, 9);
        checks++;
        if (regs_flat[5*16 +: 16] !== 16'h2222 || {wr_toggle, last_wr_addr, frame_count, err_addr} !== model_status()) begin
            errors++; $display("FAIL abort_partial: got reg5=%h status=%h required 2222 %h",
                               regs_flat[5*16 +: 16], {wr_toggle, last_wr_addr, frame_count, err_addr}, model_status());
        end
        tx_words = {16'hA5A5};
        model_frame(8'hC5, 1);
        spi_frame(8'hC5, 0);
        checks++;
        if (regs_flat[5*16 +: 16] !== 16'hA5A5) begin
            errors++; $display("FAIL abort_recover: got reg5=%h required A5A5", regs_flat[5*16 +: 16]);
        end
    endtask

    task automatic test_random();
        logic [7:0] hdr;
        int nw;
        int part;
        int bad;
        for (int it = 0; it < 30; it++) begin
            hdr = {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 6'($urandom_range(0, 19))};
            nw = $urandom_range(1, 4);
            part = $urandom_range(0, 5);
            tx_words = {};
            for (int k = 0; k < nw; k++) tx_words.push_back(16'($urandom));
            model_frame(hdr, nw);
            spi_frame(hdr, part);
            if (!hdr[7]) begin
                bad = 0;
                for (int k = 0; k < nw; k++) if (rx_words[k] !== exp_q[k]) bad++;
                checks++;
                if (bad != 0) begin
                    errors++; $display("FAIL rand_read hdr=%h: got first %h required %h (%0d bad)",
                                       hdr, rx_words[0], exp_q[0], bad);
                end
            end
            checks++;
            if (regs_flat !== model_flat()) begin
                errors++; $display("FAIL rand_bank hdr=%h: got %h required %h", hdr, regs_flat, model_flat());
            end
            checks++;
            if ({wr_toggle, last_wr_addr, frame_count, err_addr} !== model_status()) begin
                errors++; $display("FAIL rand_status hdr=%h: got %h required %h",
                                   hdr, {wr_toggle, last_wr_addr, frame_count, err_addr}, model_status());
            end
        end
    endtask

    task automatic test_lsb_variant();
        logic [7:0] r;
        spi8_frame(8'h80, 8'h01, r);
        checks++;
        if (regs_flat8 !== 32'h0000_0001) begin
            errors++; $display("FAIL lsb_write0: got %h required 00000001", regs_flat8);
        end
        spi8_frame(8'h83, 8'hB4, r);
        spi8_frame(8'h03, 8'h00, r);
        checks++;
        if (r !== 8'hB4 || regs_flat8 !== 32'hB400_0001) begin
            errors++; $display("FAIL lsb_readback: got r=%h flat=%h required B4 B4000001", r, regs_flat8);
        end
        checks++;
        if ({wr_toggle8, last_wr_addr8, frame_count8, err_addr8} !== {1'b0, 6'd3, 8'd3, 1'b0}) begin
            errors++; $display("FAIL lsb_status: got tog=%b last=%0d fc=%0d err=%b required 0 3 3 0",
                               wr_toggle8, last_wr_addr8, frame_count8, err_addr8);
        end
    endtask

    task automatic test_reset_midword();
        logic [7:0] hdr;
        hdr = 8'hC5;
        for (int i = 7; i >= 0; i--) begin
            @(negedge sclk);
            spi.spi_cs_n = 1'b0;
            spi.spi_mosi = hdr[i];
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge sclk);
            spi.spi_mosi = 1'b1;
        end
        @(posedge sclk); #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (regs_flat !== 256'd0 || {wr_toggle, last_wr_addr, frame_count, err_addr} !== 16'h0000
            || spi.spi_miso !== 1'b0 || regs_flat8 !== 32'd0) begin
            errors++; $display("FAIL reset_midword: got flat=%h status=%h miso=%b required all 0",
                               regs_flat, {wr_toggle, last_wr_addr, frame_count, err_addr}, spi.spi_miso);
        end
        @(negedge sclk);
        spi.spi_cs_n = 1'b1;
        spi.spi_mosi = 1'b0;
        @(negedge sclk);
        rst_n = 1'b1;
        model_reset();
        tx_words = {16'($urandom), 16'($urandom)};
        model_frame(8'hCE, 2);
        spi_frame(8'hCE, 0);
        checks++;
        if (regs_flat !== model_flat() || {wr_toggle, last_wr_addr, frame_count, err_addr} !== model_status()) begin
            errors++; $display("FAIL reset_recover: got %h status %h required %h status %h", regs_flat,
                               {wr_toggle, last_wr_addr, frame_count, err_addr}, model_flat(), model_status());
        end
    endtask

    initial begin
        spi.spi_cs_n  = 1'b1;
        spi.spi_mosi  = 1'b0;
        spi8.spi_cs_n = 1'b1;
        spi8.spi_mosi = 1'b0;
        model_reset();
        repeat (3) @(negedge sclk);
        #1;
        test_reset();
        rst_n = 1'b1;
        @(negedge sclk);
        test_basic_write();
        test_readback();
        test_wrap_noai();
        test_out_of_range();
        test_abort();
        test_random();
        test_lsb_variant();
        test_reset_midword();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
